// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter sharing one memory port among NUM_CORES cores
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   core_req/core_we               per-core request valid and op (1 = write)
//   core_addr/core_wdata           per-core address / write data, core i at [i*W +: W]
//   core_lock                      per-core lock, present only when ARB_LOCK_EN is defined
//   core_stall                     per-core stall, high while a request is pending
//   core_rvalid                    one-cycle completion pulse per core
//   core_rdata                     shared read data, valid with any core_rvalid bit
//   grant_id                       index of the core currently or last granted
//   mem_en/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata              memory completion and read data
//
// Optional feature macro: ARB_LOCK_EN (lock-based regrant for atomic sequences).
module shared_mem_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]        core_lock,
`endif
    output logic [NUM_CORES-1:0]        core_stall,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [2:0]                  grant_id,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    logic [2:0]            r_last;
    logic [2:0]            r_grant;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [NUM_CORES-1:0]  r_rvalid;
    logic [DATA_W-1:0]     r_rdata;
`ifdef ARB_LOCK_EN
    logic                  r_lock_hold;
    logic                  w_gnt_lock;
    logic                  w_gnt_req;
`endif

    logic                  w_any;
    logic [2:0]            w_sel;
    logic                  w_sel_we;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [NUM_CORES-1:0]  w_gnt_onehot;

    // Round-robin pick: first requester above r_last, else first at or below it.
    // Loops index by constant loop variables so no narrow-index arithmetic is needed.
    always_comb begin
        w_any        = 1'b0;
        w_sel        = r_last;
        w_sel_we     = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_gnt_onehot = '0;
`ifdef ARB_LOCK_EN
        w_gnt_lock   = 1'b0;
        w_gnt_req    = 1'b0;
`endif
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_any && core_req[i] && (i > int'(r_last))) begin
                w_any = 1'b1;
                w_sel = 3'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_any && core_req[i] && (i <= int'(r_last))) begin
                w_any = 1'b1;
                w_sel = 3'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (3'(i) == r_grant) begin
                w_gnt_onehot[i] = 1'b1;
`ifdef ARB_LOCK_EN
                w_gnt_lock      = core_lock[i];
                w_gnt_req       = core_req[i];
`endif
            end
        end
`ifdef ARB_LOCK_EN
        // A lock captured in RESP regrants the same core if it is still requesting.
        if (r_lock_hold && w_gnt_req) begin
            w_any = 1'b1;
            w_sel = r_grant;
        end
`endif
        for (int i = 0; i < NUM_CORES; i++) begin
            if (3'(i) == w_sel) begin
                w_sel_we    = core_we[i];
                w_sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_last      <= 3'(NUM_CORES - 1);
            r_grant     <= 3'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
`ifdef ARB_LOCK_EN
            r_lock_hold <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rvalid <= '0;
`ifdef ARB_LOCK_EN
                    // The hold is good for this one IDLE cycle only.
                    r_lock_hold <= 1'b0;
`endif
                    if (w_any) begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_grant     <= w_sel;
                        r_last      <= w_sel;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_rvalid <= w_gnt_onehot;
                        r_mem_en <= 1'b0;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rvalid <= '0;
`ifdef ARB_LOCK_EN
                    r_lock_hold <= w_gnt_lock;
`endif
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_rvalid <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign core_stall  = core_req & ~r_rvalid;
    assign core_rvalid = r_rvalid;
    assign core_rdata  = r_rdata;
    assign grant_id    = r_grant;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb/tb_shared_mem_arbiter.sv - directed self-checking bench for shared_mem_arbiter
module tb_shared_mem_arbiter;
    localparam int NC = 2;
    localparam int AW = 9;
    localparam int DW = 32;

    logic              clk;
    logic              resetn;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_we;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
`ifdef ARB_LOCK_EN
    logic [NC-1:0]     core_lock;
`endif
    logic [NC-1:0]     core_stall;
    logic [NC-1:0]     core_rvalid;
    logic [DW-1:0]     core_rdata;
    logic [2:0]        grant_id;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_ack;
    logic [DW-1:0]     mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    shared_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
`ifdef ARB_LOCK_EN
        .core_lock   (core_lock),
`endif
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .grant_id    (grant_id),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_core(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we[c]             = we;
        core_addr[c*AW +: AW]  = a;
        core_wdata[c*DW +: DW] = d;
    endtask

    // Waits (bounded) for a grant, holds mem_ack low for 'delay' ACCESS cycles,
    // then acks and checks the completion. Returns at the RESP-cycle negedge.
    task automatic do_txn(input string tag, input int delay, input logic [DW-1:0] rd,
                          input logic [2:0] exp_gid, input logic exp_we,
                          input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_rdata);
        int waited;
        logic [AW-1:0] a0;
        logic [NC-1:0] onehot;
        waited = 0;
        while (!mem_en && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_mem_en"}, mem_en, 1);
        check({tag, "_gid"}, grant_id, exp_gid);
        check({tag, "_we"}, mem_we, exp_we);
        check({tag, "_addr"}, mem_addr, exp_addr);
        a0 = mem_addr;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check({tag, "_hold_en"}, mem_en, 1);
            check({tag, "_hold_addr"}, mem_addr, a0);
            check({tag, "_hold_rvalid"}, core_rvalid, 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack   = 1'b0;
        onehot    = 2'b01 << exp_gid;
        check({tag, "_rvalid"}, core_rvalid, onehot);
        check({tag, "_en_drop"}, mem_en, 0);
        check({tag, "_rdata"}, core_rdata, exp_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
`ifdef ARB_LOCK_EN
        core_lock  = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rvalid", core_rvalid, 0);
        check("rst_rdata", core_rdata, 0);
        check("rst_gid", grant_id, 0);
        check("rst_stall", core_stall, 0);

        // Single read by core 0
        resetn = 1'b1;
        set_core(0, 1'b0, 9'h005, 32'h0);
        core_req = 2'b01;
        #1;
        check("rd_stall_req", core_stall, 2'b01);
        do_txn("rd", 0, 32'hDEADBEEF, 3'd0, 1'b0, 9'h005, 32'hDEADBEEF);
        check("rd_stall_done", core_stall, 2'b00);
        core_req = 2'b00;
        @(negedge clk);
        check("rd_rvalid_clr", core_rvalid, 0);

        // Contention from reset: core0 write, core1 read
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        set_core(0, 1'b1, 9'h010, 32'h11111111);
        set_core(1, 1'b0, 9'h020, 32'h0);
        core_req = 2'b11;
        do_txn("ct0", 0, 32'h55555555, 3'd0, 1'b1, 9'h010, 32'h0);
        check("ct0_wdata_seen", dut.r_mem_wdata, 32'h11111111);
        check("ct0_stall1", core_stall, 2'b10);
        core_req = 2'b10;
        @(negedge clk);
        check("ct_idle_stall1", core_stall, 2'b10);
        do_txn("ct1", 0, 32'hCAFEF00D, 3'd1, 1'b0, 9'h020, 32'hCAFEF00D);
        core_req = 2'b00;
        @(negedge clk);

        // Fairness: both cores request continuously (last grant was core 1)
        set_core(0, 1'b0, 9'h0A0, 32'h0);
        set_core(1, 1'b0, 9'h0B1, 32'h0);
        core_req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0)
                do_txn("fair0", 0, 32'h100 + t, 3'd0, 1'b0, 9'h0A0, 32'h100 + t);
            else
                do_txn("fair1", 0, 32'h100 + t, 3'd1, 1'b0, 9'h0B1, 32'h100 + t);
        end
        core_req = 2'b00;
        @(negedge clk);

        // Slow memory on core 1, then spurious acks while idle
        set_core(1, 1'b0, 9'h1AB, 32'h0);
        core_req = 2'b10;
        do_txn("slow", 5, 32'h0BADF00D, 3'd1, 1'b0, 9'h1AB, 32'h0BADF00D);
        core_req = 2'b00;
        @(negedge clk);
        check("slow_single_pulse", core_rvalid, 0);
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("spur_rvalid", core_rvalid, 0);
            check("spur_mem_en", mem_en, 0);
        end
        mem_ack = 1'b0;

        // Reset during ACCESS of core 0; without reset core 1 would win next
        set_core(0, 1'b0, 9'h033, 32'h0);
        core_req = 2'b01;
        @(negedge clk);
        check("ra_granted", mem_en, 1);
        check("ra_gid", grant_id, 0);
        resetn = 1'b0;
        @(negedge clk);
        check("ra_en_drop", mem_en, 0);
        check("ra_no_rvalid", core_rvalid, 0);
        check("ra_gid_rst", grant_id, 0);
        set_core(1, 1'b0, 9'h044, 32'h0);
        core_req = 2'b11;
        resetn = 1'b1;
        @(negedge clk);
        check("ra_no_rvalid2", core_rvalid, 0);
        do_txn("ra_after0", 0, 32'h12345678, 3'd0, 1'b0, 9'h033, 32'h12345678);
        core_req = 2'b10;
        do_txn("ra_after1", 0, 32'h87654321, 3'd1, 1'b0, 9'h044, 32'h87654321);
        core_req = 2'b00;
        @(negedge clk);

`ifdef ARB_LOCK_EN
        // Last grant was core 1: core 0 wins, lock regrants it, then core 1
        core_lock = 2'b01;
        core_req  = 2'b11;
        do_txn("lk0a", 0, 32'hA0, 3'd0, 1'b0, 9'h033, 32'hA0);
        do_txn("lk0b", 0, 32'hA1, 3'd0, 1'b0, 9'h033, 32'hA1);
        core_lock = 2'b00;
        do_txn("lk1", 0, 32'hA2, 3'd1, 1'b0, 9'h044, 32'hA2);
        core_req  = 2'b00;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Round-robin arbiter sharing one 512x32 data memory port among NUM_CORES processor cores.
- Each core presents a single outstanding read or write request and is stalled until the arbiter returns completion.
- Sits between the cores' read/write/address/write_data outputs and the memory; it drives each core's stall_cpu and returns read data.

Parameters:
- NUM_CORES, 2, number of requesting cores (2..8).
- ADDR_W, 9, memory word address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- core_req  in  NUM_CORES  per-core request valid; held until that core's rvalid.
- core_we  in  NUM_CORES  per-core op: 1 = write, 0 = read.
- core_addr  in  NUM_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing.
- core_stall  out  NUM_CORES  per-core stall (feeds core stall_cpu).
- core_rvalid  out  NUM_CORES  one-cycle completion pulse per core (reads and writes).
- core_rdata  out  DATA_W  read data, shared, valid when any core_rvalid bit is high.
- grant_id  out  3  index of core currently or last granted.
- mem_en  out  1  memory access enable, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (resetn=0 at edge): state IDLE; mem_en, mem_we, mem_addr, mem_wdata, core_rvalid, core_rdata = 0; grant_id = 0; RR pointer last = NUM_CORES-1, so core 0 wins first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any core_req is high, select the first requester searching from (last+1) mod NUM_CORES upward with wrap. On the next edge:
  - latch that core's we/addr/wdata onto mem_*;
  - set mem_en=1, grant_id=sel, last=sel;
  - go to ACCESS.
  - With no requests, stay in IDLE with mem_en=0.
- ACCESS: mem_en and mem_* are held stable. On a cycle with mem_ack=1:
  - on the next edge, latch core_rdata (from mem_rdata on reads; unchanged on writes);
  - set core_rvalid[grant_id]=1 and mem_en=0;
  - go to RESP.
  - mem_ack while mem_en=0 is ignored.
- RESP: core_rvalid is high for exactly this cycle, then cleared on the next edge; go to IDLE.
- Latency: request in an IDLE cycle with mem_ack in the first ACCESS cycle gives rvalid 2 cycles after the request. Back-to-back grants are 3 cycles apart (ACCESS, RESP, IDLE).
- core_stall[i] = core_req[i] & ~core_rvalid[i] (combinational from registered rvalid). A core not requesting is never stalled.
- Fairness: a core that keeps requesting is granted within NUM_CORES grants.
- Simultaneous requests from all cores are served in RR order.
- A request appearing during ACCESS or RESP waits for IDLE.
- A core dropping core_req before its rvalid is a protocol violation; arbiter behaviour is then undefined but it must not hang.
- Reset during ACCESS or RESP: return to IDLE and drop mem_en immediately at that edge. No rvalid is issued for the aborted access.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - adds input core_lock [NUM_CORES];
  - if core_lock[grant_id] is high during RESP and that core's core_req is high in the following IDLE cycle, the same core is granted again, bypassing RR (atomic read-modify-write sequences);
  - the lock releases when core_lock drops or the core stops requesting.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
- Single read: core0 req, we=0, addr=0x005; mem_ack one cycle after mem_en with mem_rdata=0xDEADBEEF -> mem_addr=0x005, mem_we=0; core_rvalid=2'b01 for one cycle, core_rdata=0xDEADBEEF; core_stall[0] high until rvalid.
- Contention: core0 and core1 both req from reset (core0 write 0x010 <- 0x11111111, core1 read 0x020) -> core0 granted first, core1 second; core_stall[1] stays high through core0's transaction; grant_id sequence 0,1.
- Fairness: both cores requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1; no core granted twice in a row.
- Slow memory: mem_ack delayed 5 cycles -> mem_en and mem_addr stable all 5 cycles; exactly one rvalid pulse; spurious mem_ack in IDLE -> no rvalid.
- Reset mid-access: resetn=0 during ACCESS -> next edge mem_en=0, state IDLE, no rvalid. After release, core0 is granted first.
- ARB_LOCK_EN: core0 locked and requesting, core1 requesting -> core0 granted twice consecutively; after core_lock[0]=0, core1 is granted next.
